// File: rtl/rs15_11_arbiter_if.sv
// Request/response bundle between NUM_REQ link-layer clients and the shared RS(15,11) arbiter.
// The master modport is the client/consumer side; the slave modport is the arbiter.
interface rs15_11_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_mode;
  logic [NUM_REQ*15-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic                  resp_mode;
  logic [14:0]           resp_data;
  logic                  resp_err_detected;
  logic                  resp_err_corrected;

  modport master (
    output req_valid, req_mode, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_mode, resp_data,
           resp_err_detected, resp_err_corrected
  );

  modport slave (
    input  req_valid, req_mode, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_mode, resp_data,
           resp_err_detected, resp_err_corrected
  );
endinterface

// File: rtl/rs15_11_arbiter.sv
// Round-robin scheduler sharing one RS(15,11) encoder/decoder between NUM_REQ requesters.
// Define RS_ARB_ERRCNT_EN to enable the saturating decode-error counter on err_count_o.
module rs15_11_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  rs15_11_arbiter_if.slave        bus_io,
  output logic                    busy_o,
  output logic [15:0]             err_count_o
);
  localparam int unsigned PW = ID_W + 1;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] op_id_q;
  logic [14:0]     op_data_q;
  logic            op_mode_q;
  logic            busy_q;
  logic            resp_valid_q;
  logic [ID_W-1:0] resp_id_q;
  logic            resp_mode_q;
  logic [14:0]     resp_data_q;
  logic            resp_det_q;
  logic            resp_cor_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [PW-1:0]      cand;
  logic               found;
  logic [14:0]        sel_data;
  logic               sel_mode;
  logic               handshake;

  // Rotating priority search starting at rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PW'(rr_ptr_q) + PW'(k);
      if (cand >= PW'(NUM_REQ)) begin
        cand = cand - PW'(NUM_REQ);
      end
      if (!found && bus_io.req_valid[cand[ID_W-1:0]]) begin
        grant[cand[ID_W-1:0]] = 1'b1;
        grant_idx             = cand[ID_W-1:0];
        found                 = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = bus_io.req_data[i*15 +: 15];
        sel_mode = bus_io.req_mode[i];
      end
    end
  end

  assign rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Grants are only offered in IDLE and never while reset is held.
  assign bus_io.req_ready = (state_q == StIdle && !rst) ? grant : '0;
  assign handshake        = |(bus_io.req_ready & bus_io.req_valid);

  // Shared datapath: even parity over four data groups.
  logic [14:0] enc_cw;
  logic [3:0]  syn;
  logic [14:0] dp_data;
  logic        dp_err;

  assign enc_cw = {op_data_q[10:0], ^op_data_q[10:8], ^op_data_q[7:5],
                   ^op_data_q[4:2], ^op_data_q[1:0]};
  assign syn    = {op_data_q[3] ^ (^op_data_q[14:12]), op_data_q[2] ^ (^op_data_q[11:9]),
                   op_data_q[1] ^ (^op_data_q[8:6]),   op_data_q[0] ^ (^op_data_q[5:4])};
  assign dp_data = op_mode_q ? {4'b0000, op_data_q[14:4]} : enc_cw;
  assign dp_err  = op_mode_q & (|syn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      op_id_q      <= '0;
      op_data_q    <= '0;
      op_mode_q    <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_mode_q  <= 1'b0;
      resp_data_q  <= '0;
      resp_det_q   <= 1'b0;
      resp_cor_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (handshake) begin
            op_id_q   <= grant_idx;
            op_data_q <= sel_data;
            op_mode_q <= sel_mode;
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= 1'b1;
            state_q   <= StExec;
          end
        end
        StExec: begin
          resp_id_q    <= op_id_q;
          resp_mode_q  <= op_mode_q;
          resp_data_q  <= dp_data;
          resp_det_q   <= dp_err;
          resp_cor_q   <= dp_err;
          resp_valid_q <= 1'b1;
          state_q      <= StDone;
        end
        StDone: begin
          if (bus_io.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.resp_valid         = resp_valid_q;
  assign bus_io.resp_id            = resp_id_q;
  assign bus_io.resp_mode          = resp_mode_q;
  assign bus_io.resp_data          = resp_data_q;
  assign bus_io.resp_err_detected  = resp_det_q;
  assign bus_io.resp_err_corrected = resp_cor_q;
  assign busy_o                    = busy_q;

`ifdef RS_ARB_ERRCNT_EN
  logic [15:0] err_count_q;

  // Counts on DONE entry, i.e. when an errored decode result is being registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (state_q == StExec && dp_err && err_count_q != 16'hFFFF) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count_o = err_count_q;
`else
  assign err_count_o = 16'h0000;
`endif
endmodule

// File: tb/tb_rs15_11_arbiter.sv
// Directed bench for rs15_11_arbiter: expected responses are queued at each grant and
// compared when the result is consumed.
module tb_rs15_11_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] err_count;

  rs15_11_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

  rs15_11_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_io      (bus),
    .busy_o      (busy),
    .err_count_o (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic        mode;
    logic [14:0] data;
    logic        det;
    logic        cor;
  } resp_t;

  resp_t       sb[$];
  int          checks  = 0;
  int          errors  = 0;
  logic [15:0] exp_cnt = 16'h0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] model_enc(logic [10:0] d);
    logic [3:0] p;
    p[3] = ($countones(d[10:8]) % 2) == 1;
    p[2] = ($countones(d[7:5]) % 2) == 1;
    p[1] = ($countones(d[4:2]) % 2) == 1;
    p[0] = ($countones(d[1:0]) % 2) == 1;
    return {d, p};
  endfunction

  // Decode check: re-encode the received data and compare the parity nibble.
  function automatic resp_t model(int id, bit mode, logic [14:0] w);
    resp_t       r;
    logic [14:0] re;
    r.id   = 2'(id);
    r.mode = mode;
    if (!mode) begin
      r.data = model_enc(w[10:0]);
      r.det  = 1'b0;
    end else begin
      re     = model_enc(w[14:4]);
      r.data = {4'b0000, w[14:4]};
      r.det  = (re[3:0] != w[3:0]);
    end
    r.cor = r.det;
    return r;
  endfunction

  function automatic logic [15:0] exp_err_count();
`ifdef RS_ARB_ERRCNT_EN
    return exp_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic drive_req(int id, bit v, bit mode, logic [14:0] w);
    bus.req_valid[id]          = v;
    bus.req_mode[id]           = mode;
    bus.req_data[id*15 +: 15]  = w;
  endtask

  task automatic check_resp(string tag);
    resp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_id"},   bus.resp_id,            e.id);
    chk({tag, "_mode"}, bus.resp_mode,          e.mode);
    chk({tag, "_data"}, bus.resp_data,          e.data);
    chk({tag, "_det"},  bus.resp_err_detected,  e.det);
    chk({tag, "_cor"},  bus.resp_err_corrected, e.cor);
    if (e.mode && e.det && exp_cnt != 16'hFFFF) exp_cnt++;
    chk({tag, "_errcnt"}, err_count, exp_err_count());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int last_cyc;
    int ngr;

    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_mode   = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;

    // Reset state, with every requester asking.
    @(negedge clk);
    bus.req_valid = '1;
    #1;
    chk("rst_ready",      bus.req_ready,  0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_busy",       busy,           0);
    chk("rst_err_count",  err_count,      0);
    chk("rst_resp_data",  bus.resp_data,  0);
    chk("rst_resp_id",    bus.resp_id,    0);
    chk("rst_flags",      {bus.resp_mode, bus.resp_err_detected, bus.resp_err_corrected}, 0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("idle_no_req", bus.req_ready, 0);

    // Encode from requester 0; upper input bits must be ignored.
    @(negedge clk);
    drive_req(0, 1'b1, 1'b0, {4'hA, 11'h555});
    #1 chk("enc_grant", bus.req_ready, 4'b0001);
    sb.push_back(model(0, 1'b0, {4'hA, 11'h555}));
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 15'h0);
    #1;
    chk("enc_exec_rv",   bus.resp_valid, 0);
    chk("enc_exec_busy", busy,           1);
    @(negedge clk);
    #1 chk("enc_lat_rv", bus.resp_valid, 1);
    chk("enc_data_const", bus.resp_data, 15'h5555);
    bus.resp_ready = 1'b1;
    check_resp("enc");
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    chk("enc_done_busy", busy,           0);
    chk("enc_done_rv",   bus.resp_valid, 0);

    // Corrupted decode from requester 2, then 10 cycles of backpressure.
    @(negedge clk);
    drive_req(2, 1'b1, 1'b1, 15'h1555);
    #1 chk("dec_grant", bus.req_ready, 4'b0100);
    sb.push_back(model(2, 1'b1, 15'h1555));
    @(negedge clk);
    drive_req(2, 1'b0, 1'b0, 15'h0);
    drive_req(1, 1'b1, 1'b1, 15'h5555);
    #1 chk("dec_exec_ready", bus.req_ready, 0);
    @(negedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready", bus.req_ready,  0);
      chk("bp_rv",    bus.resp_valid, 1);
      chk("bp_data",  bus.resp_data,  sb[0].data);
      chk("bp_det",   bus.resp_err_detected, sb[0].det);
      @(negedge clk);
      #1;
    end
    chk("dec_data_const", bus.resp_data, 15'h0155);
    bus.resp_ready = 1'b1;
    check_resp("dec");
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1 chk("bp_next_grant", bus.req_ready, 4'b0010);
    sb.push_back(model(1, 1'b1, 15'h5555));
    @(negedge clk);
    drive_req(1, 1'b0, 1'b0, 15'h0);
    @(negedge clk);
    #1 chk("clean_rv", bus.resp_valid, 1);
    bus.resp_ready = 1'b1;
    check_resp("dec_clean");
    @(negedge clk);
    bus.resp_ready = 1'b0;

    // Reset one cycle after a grant: job discarded, pointer back to 0.
    #1;
    drive_req(3, 1'b1, 1'b0, 15'h0123);
    #1 chk("rstx_grant", bus.req_ready, 4'b1000);
    @(negedge clk);
    drive_req(3, 1'b0, 1'b0, 15'h0);
    rst = 1'b1;
    exp_cnt = 16'h0;
    drive_req(0, 1'b1, 1'b0, 15'h02A5);
    drive_req(1, 1'b1, 1'b1, 15'h1555);
    drive_req(2, 1'b1, 1'b0, 15'h7ABC);
    drive_req(3, 1'b1, 1'b1, 15'h5554);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rstx_rv",     bus.resp_valid, 0);
      chk("rstx_busy",   busy,           0);
      chk("rstx_ready",  bus.req_ready,  0);
      chk("rstx_data",   bus.resp_data,  0);
      chk("rstx_errcnt", err_count,      0);
      @(negedge clk);
    end
    rst            = 1'b0;
    bus.resp_ready = 1'b1;

    // Round robin with all requesters asserted and no backpressure.
    last_cyc = 0;
    ngr      = 0;
    for (int cyc = 0; cyc < 40 && ngr < 5; cyc++) begin
      #1;
      if (bus.resp_valid && bus.resp_ready) check_resp("rr");
      if (bus.req_ready != '0) begin
        chk("rr_order", bus.req_ready, 1 << exp_order[ngr]);
        if (ngr > 0) chk("rr_spacing", cyc - last_cyc, 3);
        case (exp_order[ngr])
          0:       sb.push_back(model(0, 1'b0, 15'h02A5));
          1:       sb.push_back(model(1, 1'b1, 15'h1555));
          2:       sb.push_back(model(2, 1'b0, 15'h7ABC));
          default: sb.push_back(model(3, 1'b1, 15'h5554));
        endcase
        last_cyc = cyc;
        ngr++;
      end
      @(negedge clk);
    end
    chk("rr_grant_count", ngr, 5);
    bus.req_valid = '0;
    for (int cyc = 0; cyc < 10 && sb.size() != 0; cyc++) begin
      #1;
      if (bus.resp_valid && bus.resp_ready) check_resp("rr_drain");
      @(negedge clk);
    end
    chk("rr_drained", sb.size(), 0);

`ifdef RS_ARB_ERRCNT_EN
    // Saturation: preload the counter and run one more errored decode.
    force dut.err_count_q = 16'hFFFF;
    #1;
    release dut.err_count_q;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    drive_req(1, 1'b1, 1'b1, 15'h1555);
    #1 chk("sat_grant_any", 32'(bus.req_ready != '0), 1);
    sb.push_back(model(1, 1'b1, 15'h1555));
    @(negedge clk);
    drive_req(1, 1'b0, 1'b0, 15'h0);
    for (int cyc = 0; cyc < 10 && sb.size() != 0; cyc++) begin
      #1;
      if (bus.resp_valid && bus.resp_ready) check_resp("sat");
      @(negedge clk);
    end
    chk("sat_drained", sb.size(), 0);
    chk("sat_errcnt", err_count, 16'hFFFF);
`endif

    bus.resp_ready = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
